// File: rtl/inst_sram_resp_pkg.sv
// Shared constants and state encoding for the instruction SRAM responder.
package inst_sram_resp_pkg;

  localparam int unsigned REG_BUS_W       = 32;
  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned CNT_W           = 4;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/inst_sram_resp_if.sv
// Fetch-side and SRAM-side signals of the instruction responder.
interface inst_sram_resp_if
  import inst_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 20
) ();

  logic                       ce_i;
  logic [INST_ADDR_BUS_W-1:0] addr_i;
  logic                       flush_i;
  logic [REG_BUS_W-1:0]       inst_o;
  logic                       stallreq_o;
  logic [ADDR_W-1:0]          sram_addr_o;
  logic                       sram_ce_n_o;
  logic                       sram_oe_n_o;
  logic [REG_BUS_W-1:0]       sram_data_i;

  // Responder side
  modport slave (
    input  ce_i, addr_i, flush_i, sram_data_i,
    output inst_o, stallreq_o, sram_addr_o, sram_ce_n_o, sram_oe_n_o
  );

  // Fetch stage / SRAM model side
  modport master (
    output ce_i, addr_i, flush_i, sram_data_i,
    input  inst_o, stallreq_o, sram_addr_o, sram_ce_n_o, sram_oe_n_o
  );

endinterface

// File: rtl/inst_sram_resp_sram_wait_cnt.sv
// Loadable down-counter that paces SRAM wait states; flags zero.
module inst_sram_resp_sram_wait_cnt
  import inst_sram_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction-side SRAM responder: one-entry word buffer in front of an
// asynchronous SRAM with WAIT_CYCLES extra read cycles.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  inst_sram_resp_if.slave  bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_req_addr;
  logic [ADDR_W-1:0]    w_req_addr_nxt;
  logic [ADDR_W-1:0]    r_buf_addr;
  logic [ADDR_W-1:0]    w_buf_addr_nxt;
  logic                 r_buf_valid;
  logic                 w_buf_valid_nxt;
  logic [REG_BUS_W-1:0] r_inst_buf;
  logic [REG_BUS_W-1:0] w_inst_buf_nxt;
  logic                 r_sram_ce_n;
  logic                 w_sram_ce_n_nxt;
  logic                 r_sram_oe_n;
  logic                 w_sram_oe_n_nxt;
  logic [ADDR_W-1:0]    r_sram_addr;
  logic [ADDR_W-1:0]    w_sram_addr_nxt;

  logic                 w_cnt_load;
  logic                 w_cnt_dec;
  logic                 w_cnt_zero;

  logic [ADDR_W-1:0]    w_waddr;
  logic                 w_ce;
  logic                 w_hit;
  logic                 w_miss;

  assign w_waddr = bus.addr_i[ADDR_W+1:2];
  assign w_ce    = (bus.ce_i == CHIP_ENABLE);
  assign w_hit   = r_buf_valid && (r_buf_addr == w_waddr);
  assign w_miss  = w_ce && !w_hit && !bus.flush_i;

  // Buffered word is returned with zero latency on a hit.
  assign bus.inst_o      = (w_ce && w_hit) ? r_inst_buf : '0;
  assign bus.stallreq_o  = w_miss && (rst != RST_ENABLE);
  assign bus.sram_addr_o = r_sram_addr;
  assign bus.sram_ce_n_o = r_sram_ce_n;
  assign bus.sram_oe_n_o = r_sram_oe_n;

  inst_sram_resp_sram_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WAIT_CYCLES)),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero)
  );

  // State, buffer and registered SRAM pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_addr  <= '0;
      r_buf_addr  <= '0;
      r_buf_valid <= 1'b0;
      r_inst_buf  <= '0;
      r_sram_ce_n <= 1'b1;
      r_sram_oe_n <= 1'b1;
      r_sram_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_buf_addr  <= w_buf_addr_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_inst_buf  <= w_inst_buf_nxt;
      r_sram_ce_n <= w_sram_ce_n_nxt;
      r_sram_oe_n <= w_sram_oe_n_nxt;
      r_sram_addr <= w_sram_addr_nxt;
    end
  end

  // Next-state, capture and SRAM pin decode; pins follow the next state so
  // they come straight from flops.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_addr_nxt  = r_req_addr;
    w_buf_addr_nxt  = r_buf_addr;
    w_buf_valid_nxt = r_buf_valid;
    w_inst_buf_nxt  = r_inst_buf;
    w_cnt_load      = 1'b0;
    w_cnt_dec       = 1'b0;
    w_sram_ce_n_nxt = 1'b1;
    w_sram_oe_n_nxt = 1'b1;
    w_sram_addr_nxt = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_state_nxt    = ST_ACCESS;
          w_req_addr_nxt = w_waddr;
          w_cnt_load     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (bus.flush_i || !w_ce) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_inst_buf_nxt  = bus.sram_data_i;
          w_buf_addr_nxt  = r_req_addr;
          w_buf_valid_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_state_nxt == ST_ACCESS) begin
      w_sram_ce_n_nxt = 1'b0;
      w_sram_oe_n_nxt = 1'b0;
      w_sram_addr_nxt = w_req_addr_nxt;
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Randomized and directed bench for inst_sram_resp against a transaction model.
module tb_inst_sram_resp;

  localparam int unsigned WAIT   = 2;
  localparam int unsigned AW     = 20;

  logic clk;
  logic rst;

  inst_sram_resp_if #(.ADDR_W(AW)) bus ();

  inst_sram_resp #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents as a fixed hash of the word address; word 0 = 0x3C011234.
  function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
    return ((32'(a)) * 32'h9E3779B1) ^ 32'h3C011234;
  endfunction

  always_comb begin
    if (!bus.sram_ce_n_o && !bus.sram_oe_n_o) bus.sram_data_i = sram_word(bus.sram_addr_o);
    else                                       bus.sram_data_i = 32'hDEADBEEF;
  end

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: buffered word plus at most one outstanding access of
  // WAIT+1 cycles, tracked by its age.
  logic            m_valid;
  logic [AW-1:0]   m_baddr;
  logic [31:0]     m_bdata;
  logic            m_busy;
  logic [AW-1:0]   m_addr;
  int              m_age;

  logic            obs_stall;
  logic            obs_ce_n;
  logic [31:0]     obs_inst;

  task automatic model_reset();
    m_valid = 1'b0; m_baddr = '0; m_bdata = '0;
    m_busy  = 1'b0; m_addr  = '0; m_age   = 0;
  endtask

  // One cycle: drive inputs, check all outputs mid-cycle, advance model at edge.
  task automatic step(input logic ce, input logic [31:0] addr, input logic fl);
    logic [AW-1:0] wa;
    logic          hit;
    bus.ce_i = ce; bus.addr_i = addr; bus.flush_i = fl;
    #3;
    wa  = addr[AW+1:2];
    hit = m_valid && (m_baddr == wa);
    obs_stall = bus.stallreq_o;
    obs_ce_n  = bus.sram_ce_n_o;
    obs_inst  = bus.inst_o;
    chk("inst_o",      bus.inst_o,                (ce && hit) ? m_bdata : 32'h0);
    chk("stallreq_o",  32'(bus.stallreq_o),       32'(ce && !hit && !fl));
    chk("sram_ce_n_o", 32'(bus.sram_ce_n_o),      32'(!m_busy));
    chk("sram_oe_n_o", 32'(bus.sram_oe_n_o),      32'(!m_busy));
    chk("sram_addr_o", 32'(bus.sram_addr_o),      m_busy ? 32'(m_addr) : 32'h0);
    @(posedge clk);
    if (m_busy) begin
      if (fl || !ce) m_busy = 1'b0;
      else if (m_age == int'(WAIT)) begin
        m_valid = 1'b1; m_baddr = m_addr; m_bdata = sram_word(m_addr); m_busy = 1'b0;
      end else m_age++;
    end else if (ce && !hit && !fl) begin
      m_busy = 1'b1; m_addr = wa; m_age = 0;
    end
    #1;
  endtask

  // Hold a fetch until the stall clears or the budget runs out.
  task automatic fetch(input logic [31:0] addr, output int n_stall, output int n_ce);
    n_stall = 0; n_ce = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, addr, 1'b0);
      if (!obs_ce_n) n_ce++;
      if (!obs_stall) break;
      n_stall++;
    end
  endtask

  int ns, nc;

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    bus.ce_i = 1'b0; bus.addr_i = '0; bus.flush_i = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_inst",  bus.inst_o,             32'h0);
    chk("rst_stall", 32'(bus.stallreq_o),    32'h0);
    chk("rst_ce_n",  32'(bus.sram_ce_n_o),   32'h1);
    chk("rst_oe_n",  32'(bus.sram_oe_n_o),   32'h1);
    chk("rst_addr",  32'(bus.sram_addr_o),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle with ce low.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);

    // First miss on word 0.
    fetch(32'h0, ns, nc);
    chk("miss0_stall_len", 32'(ns), 32'(WAIT + 2));
    chk("miss0_ce_len",    32'(nc), 32'(WAIT + 1));
    chk("miss0_inst",      obs_inst, 32'h3C011234);

    // Sequential fetch, then re-present as a hit.
    fetch(32'h4, ns, nc);
    chk("miss1_stall_len", 32'(ns), 32'(WAIT + 2));
    step(1'b1, 32'h4, 1'b0);
    chk("hit1_stall", 32'(obs_stall), 32'h0);
    chk("hit1_ce_n",  32'(obs_ce_n),  32'h1);
    chk("hit1_inst",  obs_inst,       sram_word(20'h1));

    // Address change one cycle into ACCESS.
    step(1'b1, 32'h8, 1'b0);
    step(1'b1, 32'h8, 1'b0);
    fetch(32'h40, ns, nc);
    chk("branch_inst", obs_inst, sram_word(20'h10));

    // Flush in the second ACCESS cycle with new address.
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h180, 1'b1);
    fetch(32'h180, ns, nc);
    chk("flush_inst", obs_inst, sram_word(20'h60));
    step(1'b1, 32'h100, 1'b0);
    chk("flush_nocapture", 32'(obs_stall), 32'h1);
    fetch(32'h100, ns, nc);

    // Asynchronous reset in the middle of an access.
    step(1'b1, 32'h200, 1'b0);
    step(1'b1, 32'h200, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ce_n",  32'(bus.sram_ce_n_o), 32'h1);
    chk("arst_oe_n",  32'(bus.sram_oe_n_o), 32'h1);
    chk("arst_stall", 32'(bus.stallreq_o),  32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 32'h100, 1'b0);
    chk("arst_buf_invalid", 32'(obs_stall), 32'h1);

    // Random traffic over a small working set so hits are frequent.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      logic        ce, fl;
      a  = {10'($urandom), 17'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      ce = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 15) == 0);
      step(ce, a, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
